clock_setter: RTL and testbench

Time-entry controller for the seconds clock; it writes into the seconds digit counters rather than reading from them. It captures the current digit values, lets the user edit the high and low seconds digits with two push-buttons, then issues a one-cycle load to the counters' set/initial inputs. It gates counting while editing and sits beside the seconds counter chain at the top level.

---
 rtl/clock_setter.sv | 218 +++++++++++++++++++++
 tb/tb_clock_setter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/clock_setter.sv
// clock_setter: time-entry controller for the seconds digit counters.
//
// Captures the current seconds digits, lets the user edit the high digit
// and then the low digit with a mode and an increment push-button, and
// finally issues a one-cycle load strobe with the edited values. Counting
// is gated off while an edit is in progress. An edit with no button
// activity for p_timeout_sec seconds ticks is abandoned without a load.
//
// Optional feature macro: CLOCK_SETTER_DEC_EN
//   When defined, adds i_btn_dec, a decrement button conditioned the same
//   way as the other buttons. Inc and dec in the same cycle cancel.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous reset, active-low
//   i_btn_mode     raw mode button (active-high, asynchronous)
//   i_btn_inc      raw increment button (active-high, asynchronous)
//   i_btn_dec      raw decrement button (only with CLOCK_SETTER_DEC_EN)
//   i_second_imp   one-cycle seconds tick, used for the edit timeout
//   i_val_lsec     current low seconds digit (0..9)
//   i_val_hsec     current high seconds digit (0..5)
//   o_set          one-cycle load strobe to the counters
//   o_init_lsec    low-digit load value, valid while o_set=1
//   o_init_hsec    high-digit load value, valid while o_set=1
//   o_run_enable   1 = counters may count, 0 while editing/committing
//   o_edit_digit   00 none, 01 editing low digit, 10 editing high digit
module clock_setter #(
  parameter int p_debounce_cnt = 500000,
  parameter int p_timeout_sec  = 10
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
`ifdef CLOCK_SETTER_DEC_EN
  input  logic       i_btn_dec,
`endif
  input  logic       i_second_imp,
  input  logic [3:0] i_val_lsec,
  input  logic [2:0] i_val_hsec,
  output logic       o_set,
  output logic [3:0] o_init_lsec,
  output logic [2:0] o_init_hsec,
  output logic       o_run_enable,
  output logic [1:0] o_edit_digit
);

`ifdef CLOCK_SETTER_DEC_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  localparam int DB_W = (p_debounce_cnt > 1) ? $clog2(p_debounce_cnt) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(p_debounce_cnt - 1);
  localparam int TO_W = (p_timeout_sec > 1) ? $clog2(p_timeout_sec) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(p_timeout_sec - 1);

  typedef enum logic [1:0] {RUN, EDIT_H, EDIT_L, COMMIT} state_t;

  // Digit arithmetic with wrap-around inside the legal digit range.
  function automatic logic [2:0] hsec_step(input logic [2:0] v, input logic up);
    if (up) return (v >= 3'd5) ? 3'd0 : v + 3'd1;
    else    return (v == 3'd0) ? 3'd5 : v - 3'd1;
  endfunction

  function automatic logic [3:0] lsec_step(input logic [3:0] v, input logic up);
    if (up) return (v >= 4'd9) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? 4'd9 : v - 4'd1;
  endfunction

  // Captured digits outside their legal range are replaced by 0.
  function automatic logic [2:0] hsec_clean(input logic [2:0] v);
    return (v > 3'd5) ? 3'd0 : v;
  endfunction

  function automatic logic [3:0] lsec_clean(input logic [3:0] v);
    return (v > 4'd9) ? 4'd0 : v;
  endfunction

  logic [NB-1:0]   raw;
  logic [NB-1:0]   sync_p0;
  logic [NB-1:0]   sync_p1;
  logic [NB-1:0]   level_p2;
  logic [NB-1:0]   level_p3;
  logic [NB-1:0]   press;
  logic [DB_W-1:0] db_cnt [NB];

`ifdef CLOCK_SETTER_DEC_EN
  assign raw = {i_btn_dec, i_btn_inc, i_btn_mode};
`else
  assign raw = {i_btn_inc, i_btn_mode};
`endif

  // Stage p0/p1: two-flop synchroniser. Stage p2: debounced (accepted)
  // level, updated only after the synchronised level has disagreed with it
  // for p_debounce_cnt consecutive cycles. Stage p3: previous accepted
  // level, used for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      level_p2 <= '0;
      level_p3 <= '0;
      for (int b = 0; b < NB; b++) db_cnt[b] <= '0;
    end else begin
      sync_p0  <= raw;
      sync_p1  <= sync_p0;
      level_p3 <= level_p2;
      for (int b = 0; b < NB; b++) begin
        if (sync_p1[b] == level_p2[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          level_p2[b] <= sync_p1[b];
          db_cnt[b]   <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + DB_W'(1);
        end
      end
    end
  end

  // One-cycle press pulse on a 0->1 change of the accepted level.
  assign press = level_p2 & ~level_p3;

  logic mode_ev;
  logic step_ev;
  logic step_do;
  logic step_up;

  assign mode_ev = press[0];
`ifdef CLOCK_SETTER_DEC_EN
  // Inc and dec together still count as activity but move nothing.
  assign step_ev = press[1] | press[2];
  assign step_do = press[1] ^ press[2];
  assign step_up = press[1];
`else
  assign step_ev = press[1];
  assign step_do = press[1];
  assign step_up = 1'b1;
`endif

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [2:0]      edit_h;
  logic [3:0]      edit_l;

  // Edit FSM; all outputs are registered and follow the next state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state        <= RUN;
      to_cnt       <= '0;
      o_set        <= 1'b0;
      o_init_lsec  <= '0;
      o_init_hsec  <= '0;
      o_run_enable <= 1'b1;
      o_edit_digit <= 2'b00;
    end else begin
      o_set <= 1'b0;
      case (state)
        RUN: begin
          o_run_enable <= 1'b1;
          o_edit_digit <= 2'b00;
          if (mode_ev) begin
            edit_h       <= hsec_clean(i_val_hsec);
            edit_l       <= lsec_clean(i_val_lsec);
            to_cnt       <= '0;
            state        <= EDIT_H;
            o_run_enable <= 1'b0;
            o_edit_digit <= 2'b10;
          end
        end
        EDIT_H, EDIT_L: begin
          if (mode_ev) begin
            to_cnt <= '0;
            if (state == EDIT_H) begin
              state        <= EDIT_L;
              o_edit_digit <= 2'b01;
            end else begin
              state        <= COMMIT;
              o_set        <= 1'b1;
              o_init_hsec  <= edit_h;
              o_init_lsec  <= edit_l;
              o_edit_digit <= 2'b00;
            end
          end else if (step_ev) begin
            // A press beats a coincident timeout tick.
            to_cnt <= '0;
            if (step_do) begin
              if (state == EDIT_H) edit_h <= hsec_step(edit_h, step_up);
              else                 edit_l <= lsec_step(edit_l, step_up);
            end
          end else if (i_second_imp) begin
            if (to_cnt == TO_LAST) begin
              to_cnt       <= '0;
              state        <= RUN;
              o_run_enable <= 1'b1;
              o_edit_digit <= 2'b00;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        COMMIT: begin
          state        <= RUN;
          o_run_enable <= 1'b1;
          o_edit_digit <= 2'b00;
        end
        default: begin
          state        <= RUN;
          o_run_enable <= 1'b1;
          o_edit_digit <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_setter.sv
// Testbench for clock_setter: event-level reference model plus a
// scoreboard of expected load strobes checked by a separate monitor.
module tb_clock_setter;

  localparam int DEB = 4;
  localparam int TO  = 3;
  localparam int HOLD = 12;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic       second_imp;
  logic [3:0] val_lsec;
  logic [2:0] val_hsec;
  logic       set;
  logic [3:0] init_lsec;
  logic [2:0] init_hsec;
  logic       run_enable;
  logic [1:0] edit_digit;

  clock_setter #(.p_debounce_cnt(DEB), .p_timeout_sec(TO)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_btn_mode   (btn_mode),
    .i_btn_inc    (btn_inc),
    .i_second_imp (second_imp),
    .i_val_lsec   (val_lsec),
    .i_val_hsec   (val_hsec),
    .o_set        (set),
    .o_init_lsec  (init_lsec),
    .o_init_hsec  (init_hsec),
    .o_run_enable (run_enable),
    .o_edit_digit (edit_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = running, 1 = editing high, 2 = editing low.
  int m_mode = 0;
  int m_h = 0, m_l = 0;
  int m_init_h = 0, m_init_l = 0;
  int m_ticks = 0;
  int expq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every load strobe must match the oldest expected commit.
  logic prev_set = 1'b0;
  always @(negedge clk) begin
    if (rst_n && set) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_set actual=h%0d,l%0d required=no_set", init_hsec, init_lsec);
      end else begin
        int e;
        e = expq.pop_front();
        chk("commit_value", {init_hsec, init_lsec}, e);
        chk("commit_run_enable", run_enable, 0);
      end
      if (prev_set) chk("set_width", 2, 1);
    end
    prev_set <= set;
  end

  function automatic int model_digit();
    return (m_mode == 1) ? 2 : (m_mode == 2) ? 1 : 0;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_edit_digit"}, edit_digit, model_digit());
    chk({tag, "_run_enable"}, run_enable, (m_mode == 0) ? 1 : 0);
    chk({tag, "_init_h"}, init_hsec, m_init_h);
    chk({tag, "_init_l"}, init_lsec, m_init_l);
    chk({tag, "_set_idle"}, set, 0);
  endtask

  // Model reaction to one accepted press (mode dominates inc).
  task automatic model_press(input bit mode, input bit inc);
    if (mode) begin
      m_ticks = 0;
      if (m_mode == 0) begin
        m_h = (int'(val_hsec) <= 5) ? int'(val_hsec) : 0;
        m_l = (int'(val_lsec) <= 9) ? int'(val_lsec) : 0;
        m_mode = 1;
      end else if (m_mode == 1) begin
        m_mode = 2;
      end else begin
        m_init_h = m_h;
        m_init_l = m_l;
        expq.push_back(m_h * 16 + m_l);
        m_mode = 0;
      end
    end else if (inc && m_mode != 0) begin
      m_ticks = 0;
      if (m_mode == 1) m_h = (m_h + 1) % 6;
      else             m_l = (m_l + 1) % 10;
    end
  endtask

  task automatic press(input bit mode, input bit inc);
    model_press(mode, inc);
    @(negedge clk);
    btn_mode = mode;
    btn_inc  = inc;
    repeat (HOLD) @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic tick();
    if (m_mode != 0) begin
      m_ticks++;
      if (m_ticks >= TO) begin
        m_mode  = 0;
        m_ticks = 0;
      end
    end
    @(negedge clk);
    second_imp = 1'b1;
    @(negedge clk);
    second_imp = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_mode = 0; m_ticks = 0; m_init_h = 0; m_init_l = 0;
    chk_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; second_imp = 1'b0;
    val_lsec = 4'd0; val_hsec = 3'd0;
    repeat (3) @(negedge clk);
    chk_state("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic edit: 3/7 -> 5/8.
    val_hsec = 3'd3; val_lsec = 4'd7;
    press(1, 0); chk_state("enter_h");
    press(0, 1); press(0, 1); chk_state("inc_h");
    press(1, 0); chk_state("enter_l");
    press(0, 1);
    press(1, 0); chk_state("commit1");

    // Wrap of both digits.
    val_hsec = 3'd5; val_lsec = 4'd9;
    press(1, 0); press(0, 1); press(1, 0); press(0, 1); press(1, 0);
    chk_state("wrap");

    // Bouncing inc in EDIT_L gives exactly one increment.
    val_hsec = 3'd1; val_lsec = 4'd2;
    press(1, 0); press(1, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); btn_inc = ~btn_inc;
      @(negedge clk);
    end
    model_press(0, 1);
    @(negedge clk); btn_inc = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_inc = 1'b0;
    repeat (HOLD) @(negedge clk);
    press(1, 0); chk_state("bounce");

    // Timeout abandons the edit.
    val_hsec = 3'd2; val_lsec = 4'd4;
    press(1, 0); press(0, 1);
    tick(); tick(); chk_state("to_pending");
    tick(); chk_state("to_expired");

    // A press between ticks restarts the timeout.
    press(1, 0); tick(); tick(); press(0, 1); tick();
    chk_state("to_restart");
    tick(); tick(); chk_state("to_after_restart");

    // Mode and inc together: mode wins, digit unchanged.
    val_hsec = 3'd4; val_lsec = 4'd1;
    press(1, 0); press(1, 1); chk_state("simul");
    press(1, 0); chk_state("simul_commit");

    // Reset while editing the low digit.
    press(1, 0); press(1, 0); chk_state("pre_reset");
    do_reset();

    // Randomized sequences, including out-of-range captured values.
    for (int n = 0; n < 40; n++) begin
      int op;
      if (m_mode == 0) begin
        val_hsec = 3'($urandom_range(0, 7));
        val_lsec = 4'($urandom_range(0, 15));
      end
      op = $urandom_range(0, 9);
      if (op < 3)      press(1, 0);
      else if (op < 7) press(0, 1);
      else if (op < 8) press(1, 1);
      else             tick();
      if (n % 8 == 7) chk_state("rand");
    end
    if (m_mode == 1) press(1, 0);
    if (m_mode == 2) press(1, 0);
    repeat (10) @(negedge clk);
    chk_state("final");
    chk("queue_drain", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
